// File: rtl/sysid_regs.sv
`timescale 1ns/1ps
// sysid_regs
// ---------------------------------------------------------------------------
// Avalon-MM system-identification slave. Returns build constants (system ID,
// build timestamp, version), a byte-writable scratch register, a prescaled
// free-running uptime counter with a coherent LO/HI snapshot, and a
// control/status pair.
//
// Ports
//   clock          sole clock, all logic on the rising edge
//   reset          asynchronous, active-high
//   address[2:0]   word address
//   read           read strobe
//   write          write strobe
//   writedata[31:0] write data
//   byteenable[3:0] byte lanes for writes
//   readdata[31:0] registered read data, holds while readdatavalid is low
//   readdatavalid  one-cycle pulse qualifying readdata
//
// Handshake: there is no waitrequest, so every cycle is accepted. A read
// sampled at edge N produces readdatavalid=1 with its data after edge N.
// A write sampled at edge N updates state at edge N. When read and write
// are both high, the read is serviced and the write is dropped.
//
// Register map
//   0 SYSTEM_ID  RO      1 TIMESTAMP RO       2 VERSION RO
//   3 SCRATCH    RW byte-enabled
//   4 UPTIME_LO  RO, also latches counter[W-1:32] into the HI shadow
//   5 UPTIME_HI  RO, returns the shadow zero-extended
//   6 CONTROL    bit0 EN, bit1 CLR (write-1 pulse, reads 0)
//   7 STATUS     bit0 OVF sticky, write-1-to-clear
// ---------------------------------------------------------------------------
module sysid_regs #(
    parameter logic [31:0] SYSTEM_ID    = 32'h0,
    parameter logic [31:0] TIMESTAMP    = 32'h0,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter logic [31:0] SCRATCH_INIT = 32'h0,
    parameter int          UPTIME_WIDTH = 48,
    parameter int          PRESCALE     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam int          HW         = UPTIME_WIDTH - 32;
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    localparam logic [2:0] A_SYSID   = 3'd0;
    localparam logic [2:0] A_TSTAMP  = 3'd1;
    localparam logic [2:0] A_VERSION = 3'd2;
    localparam logic [2:0] A_SCRATCH = 3'd3;
    localparam logic [2:0] A_UP_LO   = 3'd4;
    localparam logic [2:0] A_UP_HI   = 3'd5;
    localparam logic [2:0] A_CONTROL = 3'd6;
    localparam logic [2:0] A_STATUS  = 3'd7;

    logic [31:0]             scratch_q, scratch_d;
    logic                    en_q, en_d;
    logic                    ovf_q, ovf_d;
    logic [UPTIME_WIDTH-1:0] uptime_q, uptime_d;
    logic [15:0]             presc_q, presc_d;
    logic [HW-1:0]           hi_q, hi_d;
    logic [31:0]             readdata_q, readdata_d;
    logic                    rdv_q, rdv_d;

    logic        wr_acc;
    logic        tick;
    logic        clr;
    logic        w1c;
    logic        wrap;
    logic [31:0] rd_mux;

    // A write only lands when no read shares the cycle.
    assign wr_acc = write & ~read;
    assign tick   = en_q & (presc_q == PRESC_LAST);
    assign clr    = wr_acc & (address == A_CONTROL) & byteenable[0] & writedata[1];
    assign w1c    = wr_acc & (address == A_STATUS) & byteenable[0] & writedata[0];
    // CLR suppresses the tick, so a cleared counter can never report a wrap.
    assign wrap   = tick & (&uptime_q) & ~clr;

    always_comb begin
        rd_mux = 32'h0;
        case (address)
            A_SYSID:   rd_mux = SYSTEM_ID;
            A_TSTAMP:  rd_mux = TIMESTAMP;
            A_VERSION: rd_mux = VERSION;
            A_SCRATCH: rd_mux = scratch_q;
            A_UP_LO:   rd_mux = uptime_q[31:0];
            A_UP_HI:   rd_mux = 32'(hi_q);
            A_CONTROL: rd_mux = {31'h0, en_q};
            A_STATUS:  rd_mux = {31'h0, ovf_q};
            default:   rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        scratch_d  = scratch_q;
        en_d       = en_q;
        ovf_d      = ovf_q;
        uptime_d   = uptime_q;
        presc_d    = presc_q;
        hi_d       = hi_q;
        readdata_d = readdata_q;
        rdv_d      = read;

        if (wr_acc && address == A_SCRATCH) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    scratch_d[8*b +: 8] = writedata[8*b +: 8];
                end
            end
        end

        // New EN takes effect at this edge; the counters below still use en_q.
        if (wr_acc && address == A_CONTROL && byteenable[0]) begin
            en_d = writedata[0];
        end

        if (clr) begin
            uptime_d = '0;
            presc_d  = '0;
        end else if (en_q) begin
            presc_d = tick ? 16'h0 : presc_q + 16'h1;
            if (tick) begin
                uptime_d = uptime_q + 1'b1;
            end
        end

        // The shadow and LO data both come from the pre-edge counter value,
        // so a tick on the sampling edge cannot tear the snapshot.
        if (clr) begin
            hi_d = '0;
        end else if (read && address == A_UP_LO) begin
            hi_d = uptime_q[UPTIME_WIDTH-1:32];
        end

        // Set beats a same-cycle write-1-to-clear.
        if (wrap) begin
            ovf_d = 1'b1;
        end else if (w1c) begin
            ovf_d = 1'b0;
        end

        if (read) begin
            readdata_d = rd_mux;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch_q  <= SCRATCH_INIT;
            en_q       <= 1'b1;
            ovf_q      <= 1'b0;
            uptime_q   <= '0;
            presc_q    <= '0;
            hi_q       <= '0;
            readdata_q <= 32'h0;
            rdv_q      <= 1'b0;
        end else begin
            scratch_q  <= scratch_d;
            en_q       <= en_d;
            ovf_q      <= ovf_d;
            uptime_q   <= uptime_d;
            presc_q    <= presc_d;
            hi_q       <= hi_d;
            readdata_q <= readdata_d;
            rdv_q      <= rdv_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_sysid_regs.sv
`timescale 1ns/1ps
module tb_sysid_regs;

    localparam logic [31:0] SYSID  = 32'h5151_0001;
    localparam logic [31:0] TSTAMP = 32'h6543_2100;
    localparam logic [31:0] VER    = 32'h0002_0003;
    localparam logic [31:0] SINIT  = 32'hA5A5_0000;
    localparam int          UW     = 33;
    localparam int          P      = 4;
    localparam longint      MASK   = (64'sd1 <<< UW) - 64'sd1;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'h0;
    logic [3:0]  byteenable = 4'h0;
    logic [31:0] readdata;
    logic        readdatavalid;

    always #5 clock = ~clock;

    sysid_regs #(
        .SYSTEM_ID(SYSID), .TIMESTAMP(TSTAMP), .VERSION(VER),
        .SCRATCH_INIT(SINIT), .UPTIME_WIDTH(UW), .PRESCALE(P)
    ) dut (
        .clock(clock), .reset(reset), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .readdatavalid(readdatavalid)
    );

    // ---------------- reference model ----------------
    // Uptime = base + (enabled cycles since clear) / P, modulo 2^UW.
    longint      m_base, m_cyc, m_hi;
    logic [31:0] m_scratch, m_last;
    logic        m_en, m_ovf;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    function automatic longint m_cnt();
        return (m_base + m_cyc / P) & MASK;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        longint c;
        c = m_cnt();
        case (a)
            3'd0: return SYSID;
            3'd1: return TSTAMP;
            3'd2: return VER;
            3'd3: return m_scratch;
            3'd4: return 32'(c);
            3'd5: return 32'(m_hi);
            3'd6: return {31'h0, m_en};
            default: return {31'h0, m_ovf};
        endcase
    endfunction

    task automatic model_reset();
        m_base = 0; m_cyc = 0; m_hi = 0;
        m_scratch = SINIT; m_en = 1'b1; m_ovf = 1'b0; m_last = 32'h0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic rd, input logic wr, input logic [2:0] a,
                              input logic [31:0] wd, input logic [3:0] be);
        longint c;
        logic   tck, clr, w1c, wrapped, en_new;
        c = m_cnt();
        tck = m_en && (m_cyc % P == P - 1);
        clr = 1'b0; w1c = 1'b0; wrapped = 1'b0; en_new = m_en;
        if (rd && a == 3'd4) m_hi = c >>> 32;
        if (wr && !rd) begin
            if (a == 3'd3) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_scratch[8*b +: 8] = wd[8*b +: 8];
            end else if (a == 3'd6 && be[0]) begin
                en_new = wd[0];
                clr = wd[1];
            end else if (a == 3'd7 && be[0] && wd[0]) begin
                w1c = 1'b1;
            end
        end
        if (clr) begin
            m_base = 0; m_cyc = 0; m_hi = 0;
        end else if (m_en) begin
            if (tck && c == MASK) wrapped = 1'b1;
            m_cyc++;
        end
        if (wrapped) m_ovf = 1'b1;
        else if (w1c) m_ovf = 1'b0;
        m_en = en_new;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic rd, input logic wr, input logic [2:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] e;
        read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        if (rd) exp_q.push_back(model_read(a));
        @(posedge clock);
        model_edge(rd, wr, a, wd, be);
        #1;
        chk("rdv", {31'h0, readdatavalid}, {31'h0, rd});
        if (rd) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
            chk($sformatf("read_a%0d", a), readdata, e);
            m_last = e;
        end else begin
            chk("hold", readdata, m_last);
        end
        read = 1'b0; write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b1, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b0, 1'b1, a, d, be);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        read = 1'b0; write = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("reset_rdv", {31'h0, readdatavalid}, 32'h0);
        chk("reset_rdata", readdata, 32'h0);
        reset = 1'b0;
        model_reset();
    endtask

    // Run idle cycles until the next edge is a tick edge (bounded by P).
    task automatic align_tick();
        for (int i = 0; i < P && !(m_en && (m_cyc % P == P - 1)); i++) idle(1);
        chk("align_tick", {31'h0, (m_en && (m_cyc % P == P - 1))}, 32'h1);
    endtask

    task automatic force_cnt(input logic [UW-1:0] v);
        force dut.uptime_q = v;
        #1;
        release dut.uptime_q;
        m_base = longint'(v) - m_cyc / P;
    endtask

    // ---------------- directed + random sequence ----------------
    logic [31:0] snap;

    initial begin
        model_reset();
        do_reset();

        // Constants back to back, then readdata holds.
        rd(3'd0); rd(3'd1); rd(3'd2);
        idle(2);
        chk("hold_version", readdata, VER);

        // Scratch byte lanes and RO write protection.
        rd(3'd3);
        wr(3'd3, 32'hDEAD_BEEF, 4'b1111);
        wr(3'd3, 32'h0000_0055, 4'b0001);
        rd(3'd3);
        chk("scratch_be", readdata, 32'hDEAD_BE55);
        wr(3'd0, 32'h1234_5678, 4'b1111);
        rd(3'd0);
        step(1'b1, 1'b1, 3'd3, 32'h0BAD_0BAD, 4'hF);
        rd(3'd3);
        chk("scratch_rdwr", readdata, 32'hDEAD_BE55);

        // Prescaled uptime: 40 enabled cycles after reset give 10.
        do_reset();
        idle(40);
        rd(3'd4);
        chk("uptime_40", readdata, 32'd10);
        wr(3'd6, 32'h0, 4'b0001);
        rd(3'd4);
        snap = readdata;
        idle(20);
        rd(3'd4);
        chk("uptime_frozen", readdata, snap);
        rd(3'd6);
        chk("control_en0", readdata, 32'h0);
        wr(3'd6, 32'h1, 4'b0001);

        // Coherent snapshot across the 32-bit boundary.
        align_tick();
        force_cnt(33'h0_FFFF_FFFF);
        rd(3'd4);
        chk("snap_lo", readdata, 32'hFFFF_FFFF);
        rd(3'd5);
        chk("snap_hi", readdata, 32'h0);
        rd(3'd4);
        rd(3'd5);
        chk("snap_hi_new", readdata, 32'h1);

        // Wrap from all-ones sets OVF.
        align_tick();
        force_cnt(33'h1_FFFF_FFFF);
        idle(1);
        rd(3'd4);
        chk("wrap_lo", readdata, 32'h0);
        rd(3'd7);
        chk("ovf_set", readdata, 32'h1);
        align_tick();
        force_cnt(33'h1_FFFF_FFFF);
        wr(3'd7, 32'h1, 4'b0001);
        rd(3'd7);
        chk("ovf_set_wins", readdata, 32'h1);
        wr(3'd7, 32'h1, 4'b0001);
        rd(3'd7);
        chk("ovf_w1c", readdata, 32'h0);

        // CLR beats a same-cycle tick; EN written 1 stays 1.
        idle(9);
        align_tick();
        wr(3'd6, 32'h3, 4'b0001);
        rd(3'd4);
        chk("clr_lo", readdata, 32'h0);
        rd(3'd6);
        chk("clr_en", readdata, 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset during an outstanding read.
        wr(3'd3, 32'h1357_9BDF, 4'hF);
        wr(3'd6, 32'h0, 4'b0001);
        read = 1'b1; address = 3'd3;
        @(posedge clock);
        #1;
        reset = 1'b1;
        read = 1'b0;
        #1;
        chk("rst_mid_rdv", {31'h0, readdatavalid}, 32'h0);
        chk("rst_mid_rdata", readdata, 32'h0);
        @(posedge clock);
        #1;
        chk("rst_mid_rdv2", {31'h0, readdatavalid}, 32'h0);
        reset = 1'b0;
        model_reset();
        rd(3'd3);
        chk("rst_scratch", readdata, SINIT);
        rd(3'd6);
        chk("rst_en", readdata, 32'h1);
        rd(3'd7);
        chk("rst_ovf", readdata, 32'h0);
        rd(3'd5);
        chk("rst_hi", readdata, 32'h0);
        rd(3'd4);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
